// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, LSB first,
// CLKS_PER_BIT clock cycles per serial bit, with a registered tx output.
module uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [7:0]    sr_reg, sr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bi_reg, bi_next;
  logic          tx_reg, tx_next;
  logic          bit_end;
  logic          accept;

  assign bit_end = (cnt_reg == CNT_MAX);
  // Ready reopens in the last cycle of the stop bit so frames can run back-to-back.
  assign ready   = (state_reg == IDLE) || ((state_reg == STOP) && bit_end);
  assign accept  = valid && ready;
  assign tx      = tx_reg;

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    bi_next    = bi_reg;
    tx_next    = tx_reg;
    cnt_next   = ((state_reg == IDLE) || bit_end) ? '0 : cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = START;
          sr_next    = data;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bi_next    = 3'd0;
          tx_next    = sr_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          sr_next = sr_reg >> 1;
          bi_next = bi_reg + 3'd1;
          // tx is registered, so it takes the bit that becomes sr[0] after this shift.
          if (bi_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            tx_next    = sr_reg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (accept) begin
            state_next = START;
            sr_next    = data;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sr_reg    <= 8'd0;
      cnt_reg   <= '0;
      bi_reg    <= 3'd0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
      bi_reg    <= bi_next;
      tx_reg    <= tx_next;
    end
  end

endmodule
